// File: rtl/bcd_add_datapath_n.sv
// Digit-serial N-digit packed-BCD adder datapath.
// Commands use four-phase req/ack; one fixed-priority grant per IDLE.
module bcd_add_datapath_n #(
  parameter int DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   input_value,
  input  logic                  load_a,
  input  logic                  load_b,
  input  logic                  add_start,
  input  logic                  display_a,
  input  logic                  display_b,
  input  logic                  display_ls,
  input  logic                  display_ms,
  output logic                  load_a_ack,
  output logic                  load_b_ack,
  output logic                  add_ack,
  output logic                  display_a_ack,
  output logic                  display_b_ack,
  output logic                  display_ls_ack,
  output logic                  display_ms_ack,
  output logic [4*DIGITS-1:0]   output_value,
  output logic                  carry_out,
  output logic                  bcd_err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  s;
  logic [IW-1:0] idx;
  logic          c;
  logic [6:0]    ack;

  logic [6:0]    req;
  logic [6:0]    gnt;
  logic [3:0]    da;
  logic [3:0]    db;
  logic [3:0]    sd;
  logic [4:0]    t;
  logic [4:0]    t6;
  logic          cn;
  logic          bad;
  logic          last;
  logic [W-1:0]  s_nx;

  // bit 0 is the highest priority request
  assign req = {display_ms, display_ls, display_b, display_a,
                load_b, load_a, add_start};
  assign gnt = req & (~req + 7'd1);

  assign add_ack        = ack[0];
  assign load_a_ack     = ack[1];
  assign load_b_ack     = ack[2];
  assign display_a_ack  = ack[3];
  assign display_b_ack  = ack[4];
  assign display_ls_ack = ack[5];
  assign display_ms_ack = ack[6];

  assign last = (idx == IW'(DIGITS - 1));

  // current digit select, operand validation and corrected digit sum
  always_comb begin
    da   = '0;
    db   = '0;
    bad  = 1'b0;
    s_nx = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
        bad = 1'b1;
      if (idx == IW'(i)) begin
        da = a[4*i +: 4];
        db = b[4*i +: 4];
      end
    end
    t  = {1'b0, da} + {1'b0, db} + {4'd0, c};
    t6 = t + 5'd6;
    if (t > 5'd9) begin
      sd = t6[3:0];
      cn = 1'b1;
    end else begin
      sd = t[3:0];
      cn = 1'b0;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i))
        s_nx[4*i +: 4] = sd;
    end
  end

  // command FSM and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      a            <= '0;
      b            <= '0;
      s            <= '0;
      idx          <= '0;
      c            <= 1'b0;
      ack          <= '0;
      output_value <= '0;
      carry_out    <= 1'b0;
      bcd_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          unique case (1'b1)
            gnt[0]: begin
              c       <= 1'b0;
              idx     <= '0;
              bcd_err <= bad;
              state   <= ADD;
            end
            gnt[1]: begin
              a      <= input_value;
              ack[1] <= 1'b1;
              state  <= ACK;
            end
            gnt[2]: begin
              b      <= input_value;
              ack[2] <= 1'b1;
              state  <= ACK;
            end
            gnt[3]: begin
              output_value <= a;
              ack[3]       <= 1'b1;
              state        <= ACK;
            end
            gnt[4]: begin
              output_value <= b;
              ack[4]       <= 1'b1;
              state        <= ACK;
            end
            gnt[5]: begin
              output_value <= s;
              ack[5]       <= 1'b1;
              state        <= ACK;
            end
            gnt[6]: begin
              output_value <= {{(W-1){1'b0}}, carry_out};
              ack[6]       <= 1'b1;
              state        <= ACK;
            end
            default: ;
          endcase
        end
        ADD: begin
          c <= cn;
          if (last) begin
            s         <= bcd_err ? '0 : s_nx;
            carry_out <= bcd_err ? 1'b0 : cn;
            ack[0]    <= 1'b1;
            state     <= ACK;
          end else begin
            s   <= s_nx;
            idx <= idx + IW'(1);
          end
        end
        ACK: begin
          if ((req & ack) == 7'd0) begin
            ack   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_add_datapath_n.sv
// Bench for bcd_add_datapath_n at DIGITS=2 and DIGITS=4.
// Decimal-arithmetic model plus literal expectations.
module tb_bcd_add_datapath_n;

  localparam int CADD = 0, CLA = 1, CLB = 2, CDA = 3;
  localparam int CDB = 4, CLS = 5, CMS = 6;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in2;
  logic [15:0] in4;
  logic [6:0]  req2, req4, ack2, ack4;
  logic [7:0]  out2;
  logic [15:0] out4;
  logic        co2, co4, er2, er4;

  int checks = 0;
  int errors = 0;

  logic [15:0] ma [2];
  logic [15:0] mb [2];
  logic [15:0] ms [2];
  logic [15:0] mo [2];
  logic        mc [2];
  logic        me [2];
  bit          busy [2];
  bit          hold;

  bcd_add_datapath_n #(.DIGITS(2)) u2 (
    .CLK(clk), .RST_N(rst_n), .input_value(in2),
    .load_a(req2[CLA]), .load_b(req2[CLB]), .add_start(req2[CADD]),
    .display_a(req2[CDA]), .display_b(req2[CDB]),
    .display_ls(req2[CLS]), .display_ms(req2[CMS]),
    .load_a_ack(ack2[CLA]), .load_b_ack(ack2[CLB]), .add_ack(ack2[CADD]),
    .display_a_ack(ack2[CDA]), .display_b_ack(ack2[CDB]),
    .display_ls_ack(ack2[CLS]), .display_ms_ack(ack2[CMS]),
    .output_value(out2), .carry_out(co2), .bcd_err(er2)
  );

  bcd_add_datapath_n #(.DIGITS(4)) u4 (
    .CLK(clk), .RST_N(rst_n), .input_value(in4),
    .load_a(req4[CLA]), .load_b(req4[CLB]), .add_start(req4[CADD]),
    .display_a(req4[CDA]), .display_b(req4[CDB]),
    .display_ls(req4[CLS]), .display_ms(req4[CMS]),
    .load_a_ack(ack4[CLA]), .load_b_ack(ack4[CLB]), .add_ack(ack4[CADD]),
    .display_a_ack(ack4[CDA]), .display_b_ack(ack4[CDB]),
    .display_ls_ack(ack4[CLS]), .display_ms_ack(ack4[CMS]),
    .output_value(out4), .carry_out(co4), .bcd_err(er4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] x, input int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v, input int d);
    logic [15:0] r = '0;
    int q = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(q % 10);
      q = q / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ma[k] = 0; mb[k] = 0; ms[k] = 0; mo[k] = 0;
      mc[k] = 0; me[k] = 0; busy[k] = 0;
    end
  endtask

  task automatic model_cmd(input int k, input int sel, input logic [15:0] v);
    int d, lim, sum;
    bit bad;
    d = k ? 4 : 2;
    lim = k ? 10000 : 100;
    case (sel)
      CLA: ma[k] = v;
      CLB: mb[k] = v;
      CDA: mo[k] = ma[k];
      CDB: mo[k] = mb[k];
      CLS: mo[k] = ms[k];
      CMS: mo[k] = {15'd0, mc[k]};
      default: begin
        bad = 0;
        for (int i = 0; i < d; i++)
          if (ma[k][4*i +: 4] > 9 || mb[k][4*i +: 4] > 9) bad = 1;
        me[k] = bad;
        if (bad) begin
          ms[k] = 0;
          mc[k] = 0;
        end else begin
          sum = bcd2int(ma[k], d) + bcd2int(mb[k], d);
          ms[k] = int2bcd(sum % lim, d);
          mc[k] = (sum >= lim);
        end
      end
    endcase
  endtask

  function automatic logic ackbit(input int k, input int sel);
    return k ? ack4[sel] : ack2[sel];
  endfunction

  task automatic setreq(input int k, input int sel, input logic v);
    if (k) req4[sel] = v;
    else   req2[sel] = v;
  endtask

  // full four-phase command with latency and release checks
  task automatic cmd(input int k, input int sel, input logic [15:0] v);
    int n;
    bit got;
    int exp_n;
    @(posedge clk); #1;
    if (k) in4 = v; else in2 = v[7:0];
    if (sel == CADD) busy[k] = 1;
    setreq(k, sel, 1'b1);
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      got = ackbit(k, sel);
    end
    if (!got) begin
      chk("ack_timeout", 16'd0, 16'd1);
    end else begin
      model_cmd(k, sel, v);
      busy[k] = 0;
      exp_n = (sel == CADD) ? (k ? 5 : 3) : 1;
      chk("ack_latency", 16'(n), 16'(exp_n));
    end
    setreq(k, sel, 1'b0);
    @(posedge clk); #1;
    chk("ack_release", {15'd0, ackbit(k, sel)}, 16'd0);
  endtask

  // continuous comparison against the model
  always @(negedge clk) begin
    if (rst_n && !hold) begin
      chk("out2", {8'd0, out2}, mo[0]);
      chk("out4", out4, mo[1]);
      if (!busy[0]) begin
        chk("carry2", {15'd0, co2}, {15'd0, mc[0]});
        chk("err2", {15'd0, er2}, {15'd0, me[0]});
      end
      if (!busy[1]) begin
        chk("carry4", {15'd0, co4}, {15'd0, mc[1]});
        chk("err4", {15'd0, er4}, {15'd0, me[1]});
      end
    end
  end

  initial begin
    hold = 1;
    rst_n = 0;
    req2 = 0; req4 = 0; in2 = 0; in4 = 0;
    model_reset();
    #22;
    chk("rst_out2", {8'd0, out2}, 16'h0);
    chk("rst_ack2", {9'd0, ack2}, 16'h0);
    chk("rst_out4", out4, 16'h0);
    chk("rst_flags", {14'd0, co2, er2}, 16'h0);
    rst_n = 1;
    hold = 0;

    cmd(0, CLA, 16'h47);
    cmd(0, CLB, 16'h38);
    cmd(0, CADD, 0);
    cmd(0, CLS, 0);
    chk("ls_4738", {8'd0, out2}, 16'h85);
    cmd(0, CMS, 0);
    chk("ms_4738", {8'd0, out2}, 16'h00);
    chk("flags_4738", {14'd0, co2, er2}, 16'h0);

    cmd(0, CLA, 16'h99);
    cmd(0, CLB, 16'h99);
    cmd(0, CADD, 0);
    cmd(0, CLS, 0);
    chk("ls_9999", {8'd0, out2}, 16'h98);
    cmd(0, CMS, 0);
    chk("ms_9999", {8'd0, out2}, 16'h01);
    chk("co_9999", {15'd0, co2}, 16'h1);

    cmd(1, CLA, 16'h9999);
    cmd(1, CLB, 16'h0001);
    cmd(1, CADD, 0);
    cmd(1, CLS, 0);
    chk("ls_d4", out4, 16'h0000);
    cmd(1, CMS, 0);
    chk("ms_d4", out4, 16'h0001);
    cmd(1, CLA, 16'h1234);
    cmd(1, CLB, 16'h5678);
    cmd(1, CADD, 0);
    cmd(1, CLS, 0);
    chk("ls_d4b", out4, 16'h6912);

    cmd(0, CLA, 16'h4A);
    cmd(0, CLB, 16'h01);
    cmd(0, CADD, 0);
    chk("err_4a", {15'd0, er2}, 16'h1);
    cmd(0, CLS, 0);
    chk("ls_4a", {8'd0, out2}, 16'h00);
    cmd(0, CMS, 0);
    chk("ms_4a", {8'd0, out2}, 16'h00);
    cmd(0, CDA, 0);
    chk("da_4a", {8'd0, out2}, 16'h4A);

    // simultaneous load_a and display_b: load_a wins, one idle bubble
    cmd(0, CLB, 16'h23);
    @(posedge clk); #1;
    in2 = 8'h55;
    req2[CLA] = 1;
    req2[CDB] = 1;
    @(posedge clk); #1;
    model_cmd(0, CLA, 16'h55);
    chk("arb_la_ack", {15'd0, ack2[CLA]}, 16'h1);
    chk("arb_db_wait", {15'd0, ack2[CDB]}, 16'h0);
    @(posedge clk); #1;
    chk("arb_la_hold", {15'd0, ack2[CLA]}, 16'h1);
    req2[CLA] = 0;
    @(posedge clk); #1;
    chk("arb_la_drop", {15'd0, ack2[CLA]}, 16'h0);
    chk("arb_bubble", {15'd0, ack2[CDB]}, 16'h0);
    @(posedge clk); #1;
    model_cmd(0, CDB, 0);
    chk("arb_db_ack", {15'd0, ack2[CDB]}, 16'h1);
    chk("arb_db_out", {8'd0, out2}, 16'h23);
    req2[CDB] = 0;
    @(posedge clk); #1;
    chk("arb_db_drop", {15'd0, ack2[CDB]}, 16'h0);
    cmd(0, CDA, 0);
    chk("arb_a_loaded", {8'd0, out2}, 16'h55);

    // reset pulse one cycle into an add
    @(posedge clk); #1;
    busy[0] = 1;
    req2[CADD] = 1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    hold = 1;
    rst_n = 0;
    #1;
    chk("mid_rst_out", {8'd0, out2}, 16'h0);
    chk("mid_rst_ack", {9'd0, ack2}, 16'h0);
    chk("mid_rst_flags", {14'd0, co2, er2}, 16'h0);
    chk("mid_rst_out4", out4, 16'h0);
    req2 = 0;
    model_reset();
    #3;
    rst_n = 1;
    hold = 0;
    cmd(0, CLS, 0);
    chk("post_rst_ls", {8'd0, out2}, 16'h00);
    cmd(0, CDA, 0);
    chk("post_rst_a", {8'd0, out2}, 16'h00);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_add_datapath_n.md
# bcd_add_datapath_n

Parametrised, digit-serial BCD adder datapath for the lab BCD-add system. It holds two N-digit packed-BCD operands, adds them one digit per clock with decimal correction, and presents operands or result halves on `output_value`. Commands arrive from the BCD-add controller over per-command four-phase req/ack pairs. It is the successor to the fixed two-digit datapath: the digit count is generic, the decimal correction is real, operands are validated and arbitration is defined.

## Interface
Parameters:
- `DIGITS`, default 2: BCD digits per operand (1..8). `W = 4*DIGITS` is derived, not overridable.

Ports:
- `CLK`, input, 1: single clock. All state changes on rising edge.
- `RST_N`, input, 1: reset, asynchronous, active-low.
- `input_value`, input, W: packed BCD operand. Digit 0 is in bits [3:0].
- `load_a`, `load_b`, `add_start`, `display_a`, `display_b`, `display_ls`, `display_ms`, input, 1 each: command requests.
- `load_a_ack`, `load_b_ack`, `add_ack`, `display_a_ack`, `display_b_ack`, `display_ls_ack`, `display_ms_ack`, output, 1 each: command acknowledges.
- `output_value`, output, W: display register.
- `carry_out`, output, 1: decimal carry out of the most significant digit of the last add.
- `bcd_err`, output, 1: the last add saw a nibble greater than 9 in A or B.

## Operation
- Registers: A[W], B[W], S[W] (sum), carry_out, bcd_err, output_value, digit index, and the FSM.
- FSM states:
  - IDLE: arbitrate among asserted requests and grant exactly one.
  - ADD: digit-serial add.
  - ACK: hold the granted ack.
- Fixed priority: `add_start` > `load_a` > `load_b` > `display_a` > `display_b` > `display_ls` > `display_ms`. Ungranted requests simply wait; nothing is lost or queued.
- Requests are sampled only in IDLE. Requests raised while in ADD or ACK are served later, through IDLE.
- Actions at the grant edge:
  - load_a: A ← input_value. load_b: B ← input_value.
  - display_a: output_value ← A. display_b: output_value ← B. display_ls: output_value ← S.
  - display_ms: output_value ← {0…0, 000, carry_out}.
  - All of these go to ACK with the matching ack set.
- add_start grant:
  - Clear the internal carry and set the digit index to 0.
  - bcd_err ← 1 if any nibble of A or B is greater than 9, otherwise 0.
  - Go to ADD.
- ADD, each cycle for digit i:
  - t = A_i + B_i + c (5 bits).
  - If t > 9: S_i ← t+6 (low 4 bits), c ← 1. Otherwise S_i ← t, c ← 0.
  - After digit DIGITS-1: carry_out ← c, raise add_ack, go to ACK.
  - If bcd_err = 1, S and carry_out are forced to 0 at completion.
- ACK: the ack stays high while its req is high. At the first edge where the req is sampled low, the ack drops and the FSM returns to IDLE.
- output_value persists until the next display grant. Loads and adds never change it.
- A and B stay intact across adds, so repeated add_start recomputes the same result.

## Timing
- Reset (async assert, any state): FSM → IDLE. A, B, S, output_value, carry_out, bcd_err, digit index and all acks → 0. A reset mid-ADD discards the partial sum.
- Load/display: req high sampled at edge k → action and ack visible after edge k.
- Add: add_start sampled at edge k → digits processed at edges k+1…k+DIGITS → add_ack, S and carry_out visible after edge k+DIGITS. Latency is DIGITS cycles.
- Release: req low sampled at edge m → ack low after edge m.
- Bubble: the next grant happens at edge m+1 at the earliest, so there is one IDLE cycle between commands.
- A req that drops before being granted is ignored. A req held after its ack drops is re-granted (the controller must not do this).

## Test plan
- DIGITS=2: load A=0x47, load B=0x38, add, display_ls, display_ms → output_value 0x85 then 0x00, carry_out=0, bcd_err=0.
- DIGITS=2: A=0x99, B=0x99 → add_ack exactly 2 cycles after add_start is sampled. display_ls=0x98, display_ms=0x01, carry_out=1.
- DIGITS=4: A=0x9999, B=0x0001 → add_ack after 4 cycles. display_ls=0x0000, display_ms=0x0001.
- A=0x4A, B=0x01 → bcd_err=1, display_ls=0x00, display_ms=0x00.
- load_a and display_b raised in the same cycle → load_a_ack first, display_b_ack stays 0. After load_a drops: one idle cycle, then display_b_ack with output_value=B.
- RST_N pulsed low one cycle into ADD → all outputs 0 asynchronously. A subsequent display_ls → 0x00 and ack behaves normally.
